// File: rtl/acc_exec_pkg.sv
// acc_exec_pkg: shared constants and types for the accumulator execute stage.
//   W      - accumulator / index-register data width
//   NREG   - number of index registers (addressed by the 4-bit opa field)
//   state_t with StIdle/StRead/StExec - FSM encoding
//   strobe_t - decoded instruction strobes, order {clb, clc, iac, add}
package acc_exec_pkg;

  localparam int unsigned W    = 4;
  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRead = 2'd1;
  localparam state_t StExec = 2'd2;

  typedef struct packed {
    logic clb;
    logic clc;
    logic iac;
    logic add;
  } strobe_t;

  // True when two or more strobes are set (decoder violated one-hot).
  function automatic logic multi_strobe(strobe_t s);
    return (s.clb & s.clc) | (s.clb & s.iac) | (s.clb & s.add) |
           (s.clc & s.iac) | (s.clc & s.add) | (s.iac & s.add);
  endfunction

endpackage

// File: rtl/acc_regfile.sv
// acc_regfile: NREG x W index-register file, one synchronous write port and
// one combinational read port. All entries clear on asynchronous reset.
//   clk, rst_n          - clock, async active-low reset
//   we_i/waddr_i/wdata_i - write port
//   raddr_i/rdata_o      - read port (returns the pre-write value on collision)
module acc_regfile
  import acc_exec_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/acc_exec_unit.sv
// acc_exec_unit: accumulator execute stage. Accepts one decoded instruction
// (clb/clc/iac/add strobes + opa) per valid/ready handshake and retires it
// over IDLE -> READ -> EXEC, pulsing done_o (and illegal_o on multi-strobe).
//   clk, rst_n              - clock, async active-low reset
//   instr_valid_i/ready_o   - instruction handshake (ready only in IDLE)
//   opa_i, clb_i..add_i     - operand field and decoder strobes
//   reg_we_i/waddr_i/wdata_i - index-register load path, any state
//   acc_o, cy_o             - architectural accumulator and carry
//   done_o, illegal_o       - one-cycle retire pulses
//   zero_o                  - only when ACC_ZERO_FLAG_EN is defined: acc==0
module acc_exec_unit
  import acc_exec_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid_i,
  output logic          instr_ready_o,
  input  logic [AW-1:0] opa_i,
  input  logic          clb_i,
  input  logic          clc_i,
  input  logic          iac_i,
  input  logic          add_i,
  input  logic          reg_we_i,
  input  logic [AW-1:0] reg_waddr_i,
  input  logic [W-1:0]  reg_wdata_i,
  output logic [W-1:0]  acc_o,
  output logic          cy_o,
  output logic          done_o,
`ifdef ACC_ZERO_FLAG_EN
  output logic          zero_o,
`endif
  output logic          illegal_o
);

  state_t        state_q, state_d;
  strobe_t       strb_q, strb_d;
  logic [AW-1:0] opa_q, opa_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          cy_q, cy_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;
  logic [W-1:0]  rd_data;
  logic [W:0]    add_sum;
  logic [W:0]    iac_sum;

  acc_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (reg_we_i),
    .waddr_i (reg_waddr_i),
    .wdata_i (reg_wdata_i),
    .raddr_i (opa_q),
    .rdata_o (rd_data)
  );

  assign add_sum = {1'b0, acc_q} + {1'b0, opnd_q} + {{W{1'b0}}, cy_q};
  assign iac_sum = {1'b0, acc_q} + {{W{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    strb_d    = strb_q;
    opa_d     = opa_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cy_d      = cy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (instr_valid_i) begin
          state_d = StRead;
          opa_d   = opa_i;
          strb_d  = '{clb: clb_i, clc: clc_i, iac: iac_i, add: add_i};
        end
      end
      StRead: begin
        state_d = StExec;
        opnd_d  = rd_data;
      end
      StExec: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (multi_strobe(strb_q)) begin
          illegal_d = 1'b1;
        end else if (strb_q.clb) begin
          acc_d = '0;
          cy_d  = 1'b0;
        end else if (strb_q.clc) begin
          cy_d = 1'b0;
        end else if (strb_q.iac) begin
          {cy_d, acc_d} = iac_sum;
        end else if (strb_q.add) begin
          {cy_d, acc_d} = add_sum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      strb_q    <= '0;
      opa_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cy_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      opa_q     <= opa_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cy_q      <= cy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ACC_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // acc only changes on the EXEC edge, so the flag tracks it there.
  always_comb begin
    zero_d = zero_q;
    if (state_q == StExec) zero_d = (acc_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b1;
    else        zero_q <= zero_d;
  end

  assign zero_o = zero_q;
`endif

  assign instr_ready_o = (state_q == StIdle);
  assign acc_o         = acc_q;
  assign cy_o          = cy_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;

endmodule
